// File: rtl/run_detect_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : run_detect_ctrl
// Description : Word-level controller that serialises each accepted word into a
//               run tracker and reports per-word run-of-RUN_LEN detections.
//               Optional macro RDC_MSB_FIRST_EN selects MSB-first serialisation.
// Revision    : 1.0 - initial release
// =============================================================================
module run_detect_ctrl #(
    parameter int WORD_W  = 8,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              bit_o,
    output logic              z,
    output logic              busy
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int RUN_W = $clog2(RUN_LEN + 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [RUN_W-1:0] c_RUN_LEN  = RUN_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_data;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [IDX_W-1:0]  w_sel;
    logic [RUN_W-1:0]  r_run_cnt;
    logic [RUN_W-1:0]  w_run_nxt;
    logic              r_last_bit;
    logic              r_hist_valid;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [CNT_W-1:0]  w_word_cnt_nxt;
    logic [CNT_W-1:0]  r_match_cnt;
    logic              r_z;
    logic              w_bit;
    logic              w_shift;
    logic              w_accept;
    logic              w_detect;

    assign in_ready  = (r_state == ST_IDLE) && !clr;
    assign w_accept  = in_valid && in_ready;
    assign w_shift   = (r_state == ST_SHIFT);
    assign out_valid = (r_state == ST_REPORT);
    assign busy      = (r_state != ST_IDLE);
    assign match_cnt = r_match_cnt;
    assign z         = r_z;

`ifdef RDC_MSB_FIRST_EN
    assign w_sel = c_LAST_IDX - r_bit_idx;
`else
    assign w_sel = r_bit_idx;
`endif
    assign w_bit = r_data[w_sel];
    assign bit_o = w_shift ? w_bit : 1'b0;

    // Run length saturates at RUN_LEN so every further equal bit re-detects.
    always_comb begin
        w_run_nxt = RUN_W'(1);
        if (r_hist_valid && (w_bit == r_last_bit)) begin
            w_run_nxt = (r_run_cnt == c_RUN_LEN) ? r_run_cnt : r_run_cnt + 1'b1;
        end
    end

    assign w_detect       = w_shift && (w_run_nxt == c_RUN_LEN);
    assign w_word_cnt_nxt = (w_detect && (r_word_cnt != c_CNT_MAX)) ? r_word_cnt + 1'b1
                                                                    : r_word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)                 w_state_nxt = ST_SHIFT;
            ST_SHIFT:  if (r_bit_idx == c_LAST_IDX)  w_state_nxt = ST_REPORT;
            ST_REPORT: if (out_ready)                w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
        if (clr) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_bit_idx    <= '0;
            r_run_cnt    <= '0;
            r_last_bit   <= 1'b0;
            r_hist_valid <= 1'b0;
            r_word_cnt   <= '0;
            r_match_cnt  <= '0;
            r_z          <= 1'b0;
        end else if (clr) begin
            r_bit_idx    <= '0;
            r_run_cnt    <= '0;
            r_last_bit   <= 1'b0;
            r_hist_valid <= 1'b0;
            r_word_cnt   <= '0;
            r_match_cnt  <= '0;
            r_z          <= 1'b0;
        end else begin
            r_z <= w_detect;
            if (w_accept) begin
                r_data     <= in_data;
                r_bit_idx  <= '0;
                r_word_cnt <= '0;
            end else if (w_shift) begin
                r_run_cnt    <= w_run_nxt;
                r_last_bit   <= w_bit;
                r_hist_valid <= 1'b1;
                r_word_cnt   <= w_word_cnt_nxt;
                r_bit_idx    <= r_bit_idx + 1'b1;
                if (r_bit_idx == c_LAST_IDX) begin
                    r_match_cnt <= w_word_cnt_nxt;
                end
            end
        end
    end

endmodule
`default_nettype wire
